// File: rtl/protobuf_pkg.sv
// Shared protobuf encoder definitions.
//   wire_t         : protobuf wire types this encoder knows by name
//   enc_state_t    : field encoder FSM states
//   MAX_*_BYTES    : varint length bounds for a 64-bit value and a 32-bit key
//   zigzag64()     : sint64 zigzag mapping
//   wire_supported(): true for the wire types the encoder can emit
package protobuf_pkg;

  typedef enum logic [2:0] {
    WIRE_VARINT  = 3'd0,
    WIRE_FIXED64 = 3'd1,
    WIRE_LEN     = 3'd2,
    WIRE_FIXED32 = 3'd5
  } wire_t;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    VALUE,
    FIXED,
    PAYLOAD
  } enc_state_t;

  localparam int MAX_VARINT_BYTES = 10;
  localparam int MAX_KEY_BYTES    = 5;

  // (v << 1) ^ (v >>> 63): the arithmetic shift by 63 is just the sign bit
  // replicated across all 64 bits.
  function automatic logic [63:0] zigzag64(input logic [63:0] v);
    return (v << 1) ^ {64{v[63]}};
  endfunction

  // Wire types 3 and 4 (groups) and 6/7 are not emitted by this encoder.
  function automatic logic wire_supported(input logic [2:0] w);
    return (w == WIRE_VARINT) || (w == WIRE_FIXED64) ||
           (w == WIRE_LEN)    || (w == WIRE_FIXED32);
  endfunction

endpackage

// File: rtl/proto_field_encoder_if.sv
// Handshake bundle of the protobuf field encoder.
//   fld_*  : field command (valid/ready), number, wire type, value, zigzag, last
//   pay_*  : payload byte stream for length-delimited fields (valid/ready)
//   out_*  : serialized byte stream (valid/ready) with end-of-message marker
//   err_o  : pulse on an unsupported wire type
// The encoder connects to the slave modport, the producer/consumer to master.
interface proto_field_encoder_if;
  logic        fld_valid_i;
  logic        fld_ready_o;
  logic [28:0] fld_num_i;
  logic [2:0]  fld_wire_i;
  logic [63:0] fld_value_i;
  logic        fld_zigzag_i;
  logic        fld_last_i;
  logic [7:0]  pay_data_i;
  logic        pay_valid_i;
  logic        pay_ready_o;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_last_o;
  logic        err_o;

  modport slave (
    input  fld_valid_i, fld_num_i, fld_wire_i, fld_value_i, fld_zigzag_i,
           fld_last_i, pay_data_i, pay_valid_i, out_ready_i,
    output fld_ready_o, pay_ready_o, out_data_o, out_valid_o, out_last_o,
           err_o
  );

  modport master (
    output fld_valid_i, fld_num_i, fld_wire_i, fld_value_i, fld_zigzag_i,
           fld_last_i, pay_data_i, pay_valid_i, out_ready_i,
    input  fld_ready_o, pay_ready_o, out_data_o, out_valid_o, out_last_o,
           err_o
  );
endinterface

// File: rtl/proto_varint_emit.sv
// Little-endian base-128 varint byte emitter, shared for key and value.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : present load_value; its first byte is offered the same cycle
//   load_value : value to encode
//   limit      : maximum number of bytes for this value
//   ready      : consumer takes the offered byte this cycle
//   data       : offered byte (bit7 = more bytes follow)
//   valid      : a byte is offered
//   done       : the offered byte is the final one
// A load while ready is low parks the value; the caller must not load while
// a previous value is still being emitted.
module proto_varint_emit (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] load_value,
  input  logic [3:0]  limit,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        valid,
  output logic        done
);

  logic [63:0] sreg;
  logic        active;
  logic [3:0]  cnt;
  logic [3:0]  lim;

  logic [63:0] cur;
  logic [3:0]  cur_cnt;
  logic [3:0]  cur_lim;
  logic        last_group;

  // NOTE: every always_comb output gets a value on every path (here by a
  // default at the top), otherwise synthesis infers a latch.
  always_comb begin
    cur        = sreg;
    cur_cnt    = cnt;
    cur_lim    = lim;
    if (load) begin
      cur     = load_value;
      cur_cnt = 4'd0;
      cur_lim = limit;
    end
    // The byte limit is a safety bound; a 64-bit value ends in 10 groups and
    // a 32-bit key in 5 on its own.
    last_group = (cur[63:7] == 57'd0) || (cur_cnt == cur_lim - 4'd1);
    valid      = load || active;
    done       = valid && last_group;
    data       = {!last_group, cur[6:0]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg   <= '0;
      active <= 1'b0;
      cnt    <= '0;
      lim    <= '0;
    end else if (valid && ready) begin
      if (last_group) begin
        active <= 1'b0;
      end else begin
        sreg   <= cur >> 7;
        active <= 1'b1;
        cnt    <= cur_cnt + 4'd1;
        lim    <= cur_lim;
      end
    end else if (load) begin
      sreg   <= load_value;
      active <= 1'b1;
      cnt    <= 4'd0;
      lim    <= limit;
    end
  end

endmodule

// File: rtl/proto_field_encoder.sv
// Protobuf field encoder: turns one field command into key + value bytes.
//   clk_i   : clock
//   reset_i : asynchronous active-high reset
//   bus     : field command, payload stream, output stream and error pulse
// Varint key/value/length bytes come from proto_varint_emit; fixed32/64
// bytes are shifted out of the value register; length-delimited payload
// bytes are forwarded one for one. The output byte lives in a register that
// holds while the consumer stalls.
module proto_field_encoder
  import protobuf_pkg::*;
(
  input logic                  clk_i,
  input logic                  reset_i,
  proto_field_encoder_if.slave bus
);

  enc_state_t  state;
  logic [2:0]  wire_q;
  logic        last_q;
  logic        val_started;
  logic [63:0] val_q;
  logic [3:0]  fix_cnt;
  logic [31:0] pay_cnt;

  logic        slot_free;
  logic        accept;
  logic        supported;
  logic        pay_take;
  logic [2:0]  cur_wire;
  enc_state_t  after_key;
  logic [63:0] key_in;
  logic [63:0] em_value;
  logic [3:0]  em_limit;
  logic        em_load;
  logic        em_take;
  logic [7:0]  em_data;
  logic        em_valid;
  logic        em_done;

  // Ready outputs are masked by reset so nothing is accepted while it is held.
  assign slot_free       = !bus.out_valid_o || bus.out_ready_i;
  assign bus.fld_ready_o = !reset_i && (state == IDLE) && slot_free;
  assign bus.pay_ready_o = !reset_i && (state == PAYLOAD) && slot_free;
  assign accept          = bus.fld_valid_i && bus.fld_ready_o;
  assign supported       = wire_supported(bus.fld_wire_i);
  assign pay_take        = bus.pay_valid_i && bus.pay_ready_o;

  always_comb begin
    key_in    = {32'd0, bus.fld_num_i, bus.fld_wire_i};
    cur_wire  = (state == IDLE) ? bus.fld_wire_i : wire_q;
    after_key = ((cur_wire == WIRE_FIXED64) || (cur_wire == WIRE_FIXED32)) ? FIXED : VALUE;
    em_load   = (accept && supported) || ((state == VALUE) && !val_started);
    em_value  = (state == IDLE) ? key_in : val_q;
    em_limit  = (state == IDLE) ? 4'(MAX_KEY_BYTES) : 4'(MAX_VARINT_BYTES);
    em_take   = em_valid && slot_free;
  end

  proto_varint_emit u_varint (
    .clk        (clk_i),
    .rst        (reset_i),
    .load       (em_load),
    .load_value (em_value),
    .limit      (em_limit),
    .ready      (slot_free),
    .data       (em_data),
    .valid      (em_valid),
    .done       (em_done)
  );

  // NOTE: datapath registers are reset along with control so that a field
  // abandoned by reset leaves nothing behind to leak out afterwards.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state           <= IDLE;
      wire_q          <= '0;
      last_q          <= 1'b0;
      val_started     <= 1'b0;
      val_q           <= '0;
      fix_cnt         <= '0;
      pay_cnt         <= '0;
      bus.out_data_o  <= 8'h00;
      bus.out_valid_o <= 1'b0;
      bus.out_last_o  <= 1'b0;
      bus.err_o       <= 1'b0;
    end else begin
      bus.err_o <= 1'b0;
      // A free slot with nothing new to show becomes a bubble.
      if (slot_free) begin
        bus.out_valid_o <= 1'b0;
        bus.out_last_o  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            if (supported) begin
              wire_q      <= bus.fld_wire_i;
              last_q      <= bus.fld_last_i;
              val_started <= 1'b0;
              fix_cnt     <= (bus.fld_wire_i == WIRE_FIXED64) ? 4'd8 : 4'd4;
              unique case (bus.fld_wire_i)
                WIRE_VARINT:  val_q <= bus.fld_zigzag_i ? zigzag64(bus.fld_value_i)
                                                        : bus.fld_value_i;
                WIRE_FIXED32: val_q <= {32'd0, bus.fld_value_i[31:0]};
                default:      val_q <= bus.fld_value_i;
              endcase
              // The first key byte goes straight to the output register; a
              // one-byte key skips the KEY state entirely.
              bus.out_data_o  <= em_data;
              bus.out_valid_o <= 1'b1;
              state           <= em_done ? after_key : KEY;
            end else begin
              bus.err_o <= 1'b1;
            end
          end
        end

        KEY: begin
          if (em_take) begin
            bus.out_data_o  <= em_data;
            bus.out_valid_o <= 1'b1;
            if (em_done) state <= after_key;
          end
        end

        VALUE: begin
          if (em_load) val_started <= 1'b1;
          if (em_take) begin
            bus.out_data_o  <= em_data;
            bus.out_valid_o <= 1'b1;
            if (em_done) begin
              // Payload lengths are tracked in 32 bits.
              if ((wire_q == WIRE_LEN) && (val_q[31:0] != 32'd0)) begin
                pay_cnt <= val_q[31:0];
                state   <= PAYLOAD;
              end else begin
                bus.out_last_o <= last_q;
                state          <= IDLE;
              end
            end
          end
        end

        FIXED: begin
          if (slot_free) begin
            bus.out_data_o  <= val_q[7:0];
            bus.out_valid_o <= 1'b1;
            val_q           <= val_q >> 8;
            fix_cnt         <= fix_cnt - 4'd1;
            if (fix_cnt == 4'd1) begin
              bus.out_last_o <= last_q;
              state          <= IDLE;
            end
          end
        end

        PAYLOAD: begin
          if (pay_take) begin
            bus.out_data_o  <= bus.pay_data_i;
            bus.out_valid_o <= 1'b1;
            pay_cnt         <= pay_cnt - 32'd1;
            if (pay_cnt == 32'd1) begin
              bus.out_last_o <= last_q;
              state          <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/proto_field_encoder.md
PROTO_FIELD_ENCODER -- requirements
Module: proto_field_encoder

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-002 reset_i  in  1  asynchronous, active-high reset.
REQ-003 fld_valid_i  in  1  field command valid.
REQ-004 fld_ready_o  out  1  field command accepted when fld_valid_i and fld_ready_o are both high.
REQ-005 fld_num_i  in  29  protobuf field number, 1..2^29-1.
REQ-006 fld_wire_i  in  3  wire type: 0 varint, 1 fixed64, 2 length-delimited, 5 fixed32.
REQ-007 fld_value_i  in  64  varint value, fixed value, or byte length for wire type 2.
REQ-008 fld_zigzag_i  in  1  wire type 0 only: apply zigzag (sint64) before encoding.
REQ-009 fld_last_i  in  1  field is the last one of the message.
REQ-010 pay_data_i / pay_valid_i / pay_ready_o  in 8 / in 1 / out 1  payload byte stream for wire type 2.
REQ-011 out_data_o / out_valid_o / out_ready_i  out 8 / out 1 / in 1  serialized protobuf byte stream.
REQ-012 out_last_o  out  1  final byte of a field whose fld_last_i was 1.
REQ-013 err_o  out  1  one-cycle pulse on an unsupported wire type (3, 4, 6, 7).

Function
REQ-014 The FSM SHALL use states IDLE, KEY, VALUE, FIXED, PAYLOAD.
REQ-015 fld_ready_o SHALL be high only in IDLE with no output byte pending (out_valid_o low, or out_ready_i high).
REQ-016 On acceptance, the block SHALL latch key = (fld_num_i<<3)|fld_wire_i and the value, then go to KEY; the first key byte appears on out_valid_o in the next cycle.
REQ-017 Varint emission SHALL be little-endian 7-bit groups: byte = low 7 bits, plus bit7 = 1 iff the remaining shifted value is nonzero. Value 0 emits the single byte 0x00.
REQ-018 The key is at most 5 bytes; a 64-bit value is at most 10 bytes.
REQ-019 Zigzag SHALL be computed as (v<<1) XOR (v arithmetic-shifted right by 63), 64-bit.
REQ-020 After the key, state transitions by wire type:
- wire 0 -> VALUE
- wire 2 -> VALUE (length varint), then PAYLOAD if length > 0, else IDLE
- wire 1 -> FIXED, 8 bytes
- wire 5 -> FIXED, 4 bytes, low 32 bits, least-significant byte first
REQ-021 PAYLOAD SHALL forward exactly length bytes. pay_ready_o = PAYLOAD and output slot free. A byte is transferred on pay_valid_i and pay_ready_o, and appears on out_data_o the next cycle. A 32-bit down-counter returns the FSM to IDLE after the final byte.
REQ-022 Output register: out_data_o, out_last_o and out_valid_o SHALL hold stable while out_valid_o is high and out_ready_i is low. The sustained rate is one byte per cycle under continuous out_ready_i.
REQ-023 An unsupported wire type SHALL be accepted and dropped: no bytes emitted, err_o pulses in the cycle after acceptance, FSM stays in IDLE.
REQ-024 out_last_o SHALL be asserted only on the final byte of the field (last value, fixed or payload byte; the length byte if length = 0), and only when fld_last_i was latched high.
REQ-025 Payload bubbles (pay_valid_i low) SHALL produce out_valid_o low, with no byte duplication or loss.

Reset
REQ-026 While reset_i is high:
- state = IDLE
- out_valid_o, out_last_o, err_o, pay_ready_o, fld_ready_o = 0
- out_data_o = 0x00; counters and shift registers cleared
REQ-027 Reset asserted mid-field SHALL abandon the field; after release, no residual bytes are emitted and fld_ready_o rises in the first cycle after release.

Structure
REQ-028 protobuf_pkg SHALL hold:
- wire-type enum
- MAX_VARINT_BYTES = 10
- MAX_KEY_BYTES = 5
- ZIGZAG64 function
- encoder state typedef
REQ-029 A sub-module proto_varint_emit (64-bit load, byte/valid/done, ready-stalled shift) SHALL be shared for key and value/length emission.

Verification
REQ-030 Field 1, wire 0, value 150 -> 0x08 0x96 0x01; out_last_o on 0x01 when fld_last_i = 1.
REQ-031 Field 2, wire 2, length 3, payload "abc" -> 0x12 0x03 0x61 0x62 0x63. Length 0 -> 0x12 0x00, no pay_ready_o.
REQ-032 Field 1, wire 0, zigzag, value -1 -> 0x08 0x01; field 16 value 0 -> 0x80 0x01 0x00; value 2^64-1 -> ten bytes, the last being 0x01.
REQ-033 Field 5, wire 5, value 0x11223344 -> 0x2D 0x44 0x33 0x22 0x11. Wire 1 value 1 -> 0x29 0x01 then seven 0x00.
REQ-034 out_ready_i low for 3 cycles after the 0x96 byte -> 0x96 held stable, then 0x01. Wire 3 command -> err_o single pulse, zero output bytes.
REQ-035 reset_i pulsed after 2 of 5 payload bytes -> all outputs 0. A following field 1 varint 1 yields exactly 0x08 0x01.
